// File: rtl/rename_pkg.sv
// Shared types for the rename stage: physical/architectural register ids,
// decoded-uop layout and the rename result carried to allocate.
package rename_pkg;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int PRF_W     = $clog2(NUM_PREGS);
   localparam int AREG_W    = 5;

   typedef logic [PRF_W-1:0]  t_prf_id;
   typedef logic [AREG_W-1:0] t_areg;

   typedef enum logic [1:0] {
      OP_INVD = 2'd0,
      OP_REG  = 2'd1,
      OP_IMM  = 2'd2,
      OP_ZERO = 2'd3
   } t_optype;

   typedef struct packed {
      t_optype optype;
      t_areg   opreg;
   } t_opnd;

   typedef struct packed {
      logic        valid;
      logic [7:0]  opcode;
      t_opnd       dst;
      t_opnd       src1;
      t_opnd       src2;
      logic [15:0] imm;
   } t_uinstr;

   typedef struct packed {
      t_prf_id psrc1;
      t_prf_id psrc2;
      t_prf_id pdst;
      t_prf_id pdst_old;
   } t_rename;

endpackage

// File: rtl/rename_free_list.sv
// Physical register free list with lowest-index allocator, retire free port
// and bulk restore. Define RENAME_CHK_EN for simulation-only consistency checks.
module rename_free_list
   import rename_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 alloc_en,
   output logic                 alloc_valid,
   output t_prf_id              alloc_id,
   input  logic                 free_en,
   input  t_prf_id              free_id,
   input  logic                 restore_en,
   input  logic [NUM_PREGS-1:0] restore_vec
);

   localparam logic [NUM_PREGS-1:0] RESET_FREE =
      {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
   localparam logic [NUM_PREGS-1:0] BIT0 = {{(NUM_PREGS-1){1'b0}}, 1'b1};

   logic [NUM_PREGS-1:0] free;

   // Scan from the top so the last hit is the lowest free index.
   always_comb begin
      alloc_id = '0;
      for (int i = NUM_PREGS-1; i >= 0; i--) begin
         if (free[i]) alloc_id = t_prf_id'(i);
      end
   end

   assign alloc_valid = |free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         free <= RESET_FREE;
      end else if (restore_en) begin
         free <= restore_vec & ~BIT0;
      end else begin
         if (alloc_en) free[alloc_id] <= 1'b0;
         if (free_en && free_id != '0) free[free_id] <= 1'b1;
      end
   end

`ifdef RENAME_CHK_EN
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (alloc_en && !free[alloc_id])
            $error("rename_free_list: allocating preg %0d which is not free", alloc_id);
         if (free_en && free_id != '0 && free[free_id])
            $error("rename_free_list: retire frees preg %0d which is already free", free_id);
      end
   end
`endif

endmodule

// File: rtl/rename.sv
// Register rename stage: speculative RAT, retirement RAT and registered rn1 output.
// Define RENAME_CHK_EN for simulation-only protocol/stability checks.
module rename
   import rename_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    valid_de1,
   input  t_uinstr uinstr_de1,
   output logic    rename_ready_rn0,
   input  logic    alloc_ready_ra0,
   output logic    valid_rn1,
   output t_uinstr uinstr_rn1,
   output t_rename rename_rn1,
   input  logic    retire_valid_rb1,
   input  t_areg   retire_areg_rb1,
   input  t_prf_id retire_pdst_rb1,
   input  t_prf_id retire_pdst_old_rb1,
   input  logic    br_mispred_rb1
);

   localparam logic [NUM_PREGS-1:0] RESET_USED =
      {{(NUM_PREGS-NUM_AREGS){1'b0}}, {(NUM_AREGS-1){1'b1}}, 1'b0};

   t_prf_id              rat      [NUM_AREGS];
   t_prf_id              rrat     [NUM_AREGS];
   t_prf_id              rrat_upd [NUM_AREGS];
   logic [NUM_PREGS-1:0] committed_used;
   logic [NUM_PREGS-1:0] committed_upd;
   logic                 free_any;
   logic                 fire;
   logic                 dst_reg;
   t_prf_id              alloc_id;
   t_rename              rename_rn0;
   t_uinstr              uinstr_rn0;

   assign rename_ready_rn0 = free_any & (~valid_rn1 | alloc_ready_ra0) & ~br_mispred_rb1;
   assign fire             = valid_de1 & rename_ready_rn0;
   assign dst_reg          = uinstr_de1.dst.optype == OP_REG;

   // Sources read the RAT before this uop's own destination write lands.
   always_comb begin
      rename_rn0 = '0;
      if (uinstr_de1.src1.optype == OP_REG) rename_rn0.psrc1 = rat[uinstr_de1.src1.opreg];
      if (uinstr_de1.src2.optype == OP_REG) rename_rn0.psrc2 = rat[uinstr_de1.src2.opreg];
      if (dst_reg) begin
         rename_rn0.pdst     = alloc_id;
         rename_rn0.pdst_old = rat[uinstr_de1.dst.opreg];
      end
      uinstr_rn0       = uinstr_de1;
      uinstr_rn0.valid = 1'b1;
   end

   always_comb begin
      rrat_upd      = rrat;
      committed_upd = committed_used;
      if (retire_valid_rb1) begin
         rrat_upd[retire_areg_rb1]          = retire_pdst_rb1;
         committed_upd[retire_pdst_rb1]     = 1'b1;
         committed_upd[retire_pdst_old_rb1] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_AREGS; i++) begin
            rat[i]  <= t_prf_id'(i);
            rrat[i] <= t_prf_id'(i);
         end
         committed_used <= RESET_USED;
      end else begin
         rrat           <= rrat_upd;
         committed_used <= committed_upd;
         if (br_mispred_rb1)      rat <= rrat_upd;
         else if (fire && dst_reg) rat[uinstr_de1.dst.opreg] <= alloc_id;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_rn1  <= 1'b0;
         uinstr_rn1 <= '0;
         rename_rn1 <= '0;
      end else if (br_mispred_rb1) begin
         valid_rn1        <= 1'b0;
         uinstr_rn1.valid <= 1'b0;
      end else if (fire) begin
         valid_rn1  <= 1'b1;
         uinstr_rn1 <= uinstr_rn0;
         rename_rn1 <= rename_rn0;
      end else if (alloc_ready_ra0) begin
         valid_rn1        <= 1'b0;
         uinstr_rn1.valid <= 1'b0;
      end
   end

   rename_free_list u_free_list (
      .clk         (clk),
      .reset_n     (reset_n),
      .alloc_en    (fire & dst_reg),
      .alloc_valid (free_any),
      .alloc_id    (alloc_id),
      .free_en     (retire_valid_rb1),
      .free_id     (retire_pdst_old_rb1),
      .restore_en  (br_mispred_rb1),
      .restore_vec (~committed_upd)
   );

`ifdef RENAME_CHK_EN
   always_ff @(posedge clk) begin
      if (reset_n && valid_de1 && !rename_ready_rn0)
         $error("rename: valid_de1 asserted while rename_ready_rn0 is low");
   end

   property p_stall_hold;
      @(posedge clk) disable iff (!reset_n)
         valid_rn1 && !alloc_ready_ra0 && !br_mispred_rb1
         |=> $stable(rename_rn1) && $stable(uinstr_rn1);
   endproperty
   a_stall_hold: assert property (p_stall_hold)
      else $error("rename: rn1 changed while stalled");
`endif

endmodule

// File: tb/tb_rename.sv
// Scoreboard bench for rename: directed scenarios then randomized traffic,
// checked against an array/queue model of the renaming rules.
module tb_rename;
   import rename_pkg::*;

   logic    clk = 1'b0;
   logic    reset_n;
   logic    valid_de1;
   t_uinstr uinstr_de1;
   logic    rename_ready_rn0;
   logic    alloc_ready_ra0;
   logic    valid_rn1;
   t_uinstr uinstr_rn1;
   t_rename rename_rn1;
   logic    retire_valid_rb1;
   t_areg   retire_areg_rb1;
   t_prf_id retire_pdst_rb1;
   t_prf_id retire_pdst_old_rb1;
   logic    br_mispred_rb1;

   always #5 clk = ~clk;

   rename dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .valid_de1           (valid_de1),
      .uinstr_de1          (uinstr_de1),
      .rename_ready_rn0    (rename_ready_rn0),
      .alloc_ready_ra0     (alloc_ready_ra0),
      .valid_rn1           (valid_rn1),
      .uinstr_rn1          (uinstr_rn1),
      .rename_rn1          (rename_rn1),
      .retire_valid_rb1    (retire_valid_rb1),
      .retire_areg_rb1     (retire_areg_rb1),
      .retire_pdst_rb1     (retire_pdst_rb1),
      .retire_pdst_old_rb1 (retire_pdst_old_rb1),
      .br_mispred_rb1      (br_mispred_rb1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { t_uinstr u; t_rename r; } t_exp;
   typedef struct { int areg; int pdst; int pdst_old; } t_inflight;

   t_exp      sbq[$];
   t_inflight infl[$];
   int        rat_m  [NUM_AREGS];
   int        rrat_m [NUM_AREGS];
   bit        free_m [NUM_PREGS];
   bit        used_m [NUM_PREGS];
   bit        rn1_v_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM_AREGS; i++) begin
         rat_m[i]  = i;
         rrat_m[i] = i;
      end
      for (int p = 0; p < NUM_PREGS; p++) begin
         free_m[p] = (p >= NUM_AREGS);
         used_m[p] = (p >= 1 && p < NUM_AREGS);
      end
      rn1_v_m = 1'b0;
      sbq.delete();
      infl.delete();
   endfunction

   function automatic int lowest_free();
      for (int p = 0; p < NUM_PREGS; p++)
         if (free_m[p]) return p;
      return -1;
   endfunction

   function automatic t_uinstr mk(input t_optype dt, input int rd, input t_optype t1,
                                  input int r1, input t_optype t2, input int r2);
      t_uinstr u;
      u.valid       = 1'($urandom);
      u.opcode      = 8'($urandom);
      u.dst.optype  = dt;
      u.dst.opreg   = t_areg'(rd);
      u.src1.optype = t1;
      u.src1.opreg  = t_areg'(r1);
      u.src2.optype = t2;
      u.src2.opreg  = t_areg'(r2);
      u.imm         = 16'($urandom);
      return u;
   endfunction

   function automatic t_uinstr rnd_uop();
      t_optype dt;
      dt = ($urandom_range(0, 3) == 0) ? OP_INVD : OP_REG;
      return mk(dt, $urandom_range(0, 31),
                t_optype'($urandom_range(0, 3)), $urandom_range(0, 31),
                t_optype'($urandom_range(0, 3)), $urandom_range(0, 31));
   endfunction

   // One clock of stimulus; the model advances by the same rules the DUT must obey.
   task automatic cycle(input bit de_v, input t_uinstr u, input bit ar, input bit ret, input bit mp);
      bit        model_ready;
      bit        fire;
      bit        do_ret;
      int        p;
      t_inflight rt;
      t_exp      e;
      @(posedge clk);
      #1;
      do_ret           = ret && (infl.size() > 0);
      alloc_ready_ra0  = ar;
      br_mispred_rb1   = mp;
      retire_valid_rb1 = do_ret;
      if (do_ret) begin
         rt = infl.pop_front();
         retire_areg_rb1     = t_areg'(rt.areg);
         retire_pdst_rb1     = t_prf_id'(rt.pdst);
         retire_pdst_old_rb1 = t_prf_id'(rt.pdst_old);
      end else begin
         retire_areg_rb1     = '0;
         retire_pdst_rb1     = '0;
         retire_pdst_old_rb1 = '0;
      end
      valid_de1  = 1'b0;
      uinstr_de1 = u;
      #1;
      check("valid_rn1", valid_rn1, rn1_v_m);
      check("uinstr_rn1.valid", uinstr_rn1.valid, rn1_v_m);
      model_ready = (lowest_free() >= 0) && (!rn1_v_m || ar) && !mp;
      check("rename_ready_rn0", rename_ready_rn0, model_ready);
      fire      = de_v && model_ready;
      valid_de1 = fire;
      if (fire) begin
         e.u       = u;
         e.u.valid = 1'b1;
         e.r       = '0;
         if (u.src1.optype == OP_REG) e.r.psrc1 = t_prf_id'(rat_m[u.src1.opreg]);
         if (u.src2.optype == OP_REG) e.r.psrc2 = t_prf_id'(rat_m[u.src2.opreg]);
         if (u.dst.optype == OP_REG) begin
            p            = lowest_free();
            e.r.pdst     = t_prf_id'(p);
            e.r.pdst_old = t_prf_id'(rat_m[u.dst.opreg]);
            infl.push_back('{int'(u.dst.opreg), p, rat_m[u.dst.opreg]});
            free_m[p]             = 1'b0;
            rat_m[u.dst.opreg]    = p;
         end
         sbq.push_back(e);
      end
      if (do_ret) begin
         rrat_m[rt.areg]     = rt.pdst;
         used_m[rt.pdst]     = 1'b1;
         used_m[rt.pdst_old] = 1'b0;
         if (rt.pdst_old != 0) free_m[rt.pdst_old] = 1'b1;
      end
      if (mp) begin
         rat_m = rrat_m;
         for (int q = 0; q < NUM_PREGS; q++) free_m[q] = (q != 0) && !used_m[q];
         infl.delete();
         rn1_v_m = 1'b0;
      end else if (fire) begin
         rn1_v_m = 1'b1;
      end else if (ar) begin
         rn1_v_m = 1'b0;
      end
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic expect_rn1(input string name, input int s1, input int s2, input int d, input int o);
      t_rename r;
      r.psrc1    = t_prf_id'(s1);
      r.psrc2    = t_prf_id'(s2);
      r.pdst     = t_prf_id'(d);
      r.pdst_old = t_prf_id'(o);
      check({name, " valid"}, valid_rn1, 1'b1);
      check(name, rename_rn1, r);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n             = 1'b0;
      valid_de1           = 1'b0;
      uinstr_de1          = '0;
      alloc_ready_ra0     = 1'b1;
      retire_valid_rb1    = 1'b0;
      retire_areg_rb1     = '0;
      retire_pdst_rb1     = '0;
      retire_pdst_old_rb1 = '0;
      br_mispred_rb1      = 1'b0;
      #2;
      check("reset valid_rn1", valid_rn1, 1'b0);
      check("reset rename_rn1", rename_rn1, '0);
      check("reset uinstr_rn1", uinstr_rn1, '0);
      model_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // Monitor: compare whatever rn1 presents against the oldest expected uop.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && valid_rn1 === 1'b1) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rn1 unexpected: valid_rn1=1 with nothing outstanding, pdst=%0d",
                        rename_rn1.pdst);
            end else begin
               check("rn1 rename", rename_rn1, sbq[0].r);
               check("rn1 uinstr", uinstr_rn1, sbq[0].u);
               if (alloc_ready_ra0 || br_mispred_rb1) void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      t_uinstr addi;
      reset_n             = 1'b0;
      valid_de1           = 1'b0;
      uinstr_de1          = '0;
      alloc_ready_ra0     = 1'b1;
      retire_valid_rb1    = 1'b0;
      retire_areg_rb1     = '0;
      retire_pdst_rb1     = '0;
      retire_pdst_old_rb1 = '0;
      br_mispred_rb1      = 1'b0;

      // add x3,x1,x2
      do_reset();
      cycle(1'b1, mk(OP_REG, 3, OP_REG, 1, OP_REG, 2), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("add x3", 1, 2, 32, 3);
      check("ready after add", rename_ready_rn0, 1'b1);

      // back-to-back addi x5,x5,1
      do_reset();
      addi = mk(OP_REG, 5, OP_REG, 5, OP_IMM, 0);
      cycle(1'b1, addi, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, addi, 1'b1, 1'b0, 1'b0);
      expect_rn1("addi first", 5, 0, 32, 5);
      idle();
      expect_rn1("addi second", 32, 0, 33, 32);

      // exhaust the free list, then free one preg by retire
      do_reset();
      for (int i = 0; i < 32; i++)
         cycle(1'b1, mk(OP_REG, 1, OP_REG, 1, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("last of 32", 62, 0, 63, 62);
      check("ready when empty", rename_ready_rn0, 1'b0);
      cycle(1'b1, mk(OP_REG, 1, OP_REG, 1, OP_INVD, 0), 1'b1, 1'b1, 1'b0);
      cycle(1'b1, mk(OP_REG, 1, OP_REG, 1, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("after retire", 63, 0, 1, 63);

      // downstream stall for three cycles
      do_reset();
      cycle(1'b1, mk(OP_REG, 9, OP_REG, 4, OP_REG, 6), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, mk(OP_REG, 10, OP_REG, 9, OP_INVD, 0), 1'b0, 1'b0, 1'b0);
         expect_rn1("stall hold", 4, 6, 32, 9);
         check("ready while stalled", rename_ready_rn0, 1'b0);
      end
      cycle(1'b1, mk(OP_REG, 10, OP_REG, 9, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("after stall", 32, 0, 33, 10);

      // retire x7 then mispredict
      do_reset();
      cycle(1'b1, mk(OP_REG, 7, OP_INVD, 0, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, mk(OP_REG, 8, OP_INVD, 0, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      idle();
      check("valid_rn1 after mispred", valid_rn1, 1'b0);
      cycle(1'b1, mk(OP_REG, 9, OP_REG, 7, OP_REG, 8), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("post-mispred map", 32, 8, 7, 9);
      cycle(1'b1, mk(OP_REG, 11, OP_INVD, 0, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      idle();
      expect_rn1("post-mispred next free", 0, 0, 33, 11);

      // x0 / non-register operands allocate nothing
      do_reset();
      cycle(1'b1, mk(OP_INVD, 0, OP_ZERO, 0, OP_ZERO, 0), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, mk(OP_REG, 4, OP_REG, 0, OP_INVD, 0), 1'b1, 1'b0, 1'b0);
      expect_rn1("x0 uop", 0, 0, 0, 0);
      idle();
      expect_rn1("after x0", 0, 0, 32, 4);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, rnd_uop(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++) idle();
      check("scoreboard drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rename.md
Name: rename

Overview:
- Register-rename stage, directly downstream of decode.
- Each cycle it consumes at most one decoded uop (valid_de1/uinstr_de1) and maps architectural sources and destination to physical registers using a speculative RAT and a free list.
- Emits a registered renamed uop to allocate/ROB one cycle later.
- Maintains a retirement RAT (RRAT) so the speculative map can be restored on a branch mispredict signalled from rb1.

Parameters:
- NUM_PREGS, 64, number of physical registers; must be >= 33 and a power of 2. Preg 0 is hardwired zero and never allocated.
- NUM_AREGS, 32, number of architectural registers.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- valid_de1  in  1  uop presented by decode; asserted only when rename_ready_rn0 is high
- uinstr_de1  in  t_uinstr  decoded uop
- rename_ready_rn0  out  1  rename can accept a uop this cycle
- alloc_ready_ra0  in  1  downstream accepts valid_rn1 this cycle
- valid_rn1  out  1  renamed uop valid
- uinstr_rn1  out  t_uinstr  uop copied through; its valid field equals valid_rn1
- rename_rn1  out  t_rename  {psrc1, psrc2, pdst, pdst_old}, each t_prf_id
- retire_valid_rb1  in  1  one uop with a destination retires
- retire_areg_rb1  in  5  architectural destination of the retiring uop
- retire_pdst_rb1  in  t_prf_id  its pdst
- retire_pdst_old_rb1  in  t_prf_id  previous mapping, to be freed
- br_mispred_rb1  in  1  flush and restore

Behaviour:
- Reset (async):
  - RAT[i] = RRAT[i] = i for i < NUM_AREGS.
  - Free bits set for pregs NUM_AREGS..NUM_PREGS-1; committed_used bits set for 1..NUM_AREGS-1.
  - valid_rn1 = 0; rename_rn1 = 0; uinstr_rn1 = 0.
- Ready:
  - rename_ready_rn0 = free_any & (~valid_rn1 | alloc_ready_ra0) & ~br_mispred_rb1.
  - It is a function of registered state plus alloc_ready_ra0 and br_mispred_rb1 only, never of valid_de1.
- Accept: fire = valid_de1 & rename_ready_rn0.
- Sources:
  - psrcN = RAT[srcN.opreg] if srcN.optype == OP_REG, else 0.
  - RAT is read before this uop's own write, so a uop with rs == rd sees the old mapping.
- Destination:
  - If dst.optype == OP_REG: pdst = lowest-index free preg; pdst_old = RAT[rd]; RAT[rd] <= pdst; free bit cleared.
  - Otherwise pdst = pdst_old = 0 and nothing is allocated.
- Output register:
  - On fire, load rn1 with latency 1.
  - While valid_rn1 & ~alloc_ready_ra0, rn1 holds and is bit-stable.
  - valid_rn1 clears when consumed and there is no new fire.
- Retire (retire_valid_rb1):
  - RRAT[areg] <= pdst.
  - committed_used: set pdst bit; clear pdst_old bit.
  - Free bit of pdst_old is set unless pdst_old == 0.
  - Retire and allocate in the same cycle touch distinct bits; both take effect.
- Mispredict (br_mispred_rb1):
  - Same-cycle retire is applied first.
  - RAT <= updated RRAT.
  - free <= ~updated committed_used, with bit 0 forced 0.
  - valid_rn1 <= 0; no fire that cycle.
- Free list empty: rename_ready_rn0 = 0 until a retire or mispredict frees at least one preg. A preg freed by retire is allocatable the following cycle.

Optional Feature:
- RENAME_CHK_EN defined: simulation checks that $error on:
  - allocation of a preg whose free bit is 0
  - retire freeing a preg already free
  - valid_de1 asserted while rename_ready_rn0 = 0
  - rn1 changing while stalled
- Undefined: no checks, no added logic. Functional behaviour is identical either way.

Decomposition:
- common package: NUM_PREGS default, t_prf_id (logic [$clog2(NUM_PREGS)-1:0]), t_rename struct.
- Sub-module rename_free_list holds:
  - the free bit vector
  - the lowest-index priority allocator (alloc_valid/alloc_id)
  - the free-on-retire port
  - restore-from-vector on mispredict
- RAT, RRAT and the rn1 pipeline stay in rename.

Test Plan:
- Reset, then one uop add x3,x1,x2 -> next cycle valid_rn1 = 1, psrc1 = 1, psrc2 = 2, pdst = 32, pdst_old = 3; rename_ready_rn0 = 1 throughout.
- Back-to-back addi x5,x5,1 twice -> first pdst = 32, psrc1 = 5; second psrc1 = 32, pdst = 33, pdst_old = 32.
- 32 renames of x1 with no retire -> pdst 32..63; rename_ready_rn0 = 0 afterwards; one retire with pdst_old = 1 -> ready = 1 the next cycle, next pdst = 1.
- alloc_ready_ra0 = 0 for 3 cycles with valid_rn1 = 1 -> rn1 unchanged; rename_ready_rn0 = 0; valid_de1 held off.
- Rename x7 (pdst 32) and x8 (pdst 33), retire x7, then br_mispred_rb1 -> RAT[7] = 32, RAT[8] = 8; preg 33 and 7 free; valid_rn1 = 0.
- Source/destination x0 (rd = 0, optype OP_INVD; src OP_ZERO) -> pdst = 0, psrc = 0, free list unchanged.
